// File: rtl/fetch_unit.sv
// Program counter and instruction register for the multicycle MIPS core.
// Fetches over a req/ready handshake, holds the instruction for the control unit and commits next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcupdate,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic        halted,
  output logic        seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic        seq_err_q, seq_err_d;

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  always_comb begin
    pc4        = pc_q + 32'd4;
    branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_off;
    end else begin
      next_pc = pc4;
    end
  end

  // A pcupdate outside HOLD is a control-unit sequencing bug: flag it, never act on it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    seq_err_d     = seq_err_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (pcupdate) seq_err_d = 1'b1;
      end
      FETCH: begin
        if (pcupdate) seq_err_d = 1'b1;
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          if (imem_rdata[31:26] == HALT_OPCODE) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (pcupdate) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch/update traffic
// checked against an arithmetic next-PC reference.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcupdate = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc, instr;
  logic [5:0]  opcode;
  logic        instr_valid, halted, seq_err;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pcupdate(pcupdate), .jump(jump), .branch(branch), .zero(zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .halted(halted),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          off;
    p4 = cur_pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b && z) begin
      off = int'($signed(ins[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update(input logic j, input logic b, input logic z);
    pcupdate = 1'b1; jump = j; branch = b; zero = z;
    tick();
    pcupdate = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic serve_fetch(input logic [31:0] word, input int wait_cycles);
    imem_ready = 1'b0;
    for (int i = 0; i < wait_cycles; i++) tick();
    imem_ready = 1'b1; imem_rdata = word;
    tick();
    imem_ready = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic reset_dut();
    reset = 1'b1; pcupdate = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0; imem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic first_fetch(input logic [31:0] word);
    imem_ready = 1'b1; imem_rdata = word;
    tick(); tick();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pcupdate = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1;
    imem_ready = 1'b1; imem_rdata = $urandom;
    tick(); tick(); tick();
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'd0); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if ({imem_req, instr_valid, halted, seq_err} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {imem_req, instr_valid, halted, seq_err}); end
    pcupdate = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    imem_rdata = 32'h2008_0005;
    reset = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_before_idle_edge got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++;
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ready_ignored_idle got %b exp 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || opcode !== 6'b001000) begin errors++;
      $display("FAIL first_fetch got v=%b instr=%h op=%b exp v=1 instr=20080005 op=001000", instr_valid, instr, opcode); end
    tick();
    checks++; if (imem_req !== 1'b0 || instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin errors++;
      $display("FAIL hold_stable got req=%b instr=%h v=%b exp req=0 instr=20080005 v=1", imem_req, instr, instr_valid); end
    imem_ready = 1'b0;
    $display("txn reset+first fetch pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'd0;
    for (int k = 0; k < 4; k++) begin
      pulse_update(1'b0, 1'b0, 1'b0);
      exp_pc = exp_pc + 32'd4;
      if (k == 0) begin
        checks++; if (instr !== 32'h2008_0005 || instr_valid !== 1'b0) begin errors++;
          $display("FAIL instr_kept_after_update got instr=%h v=%b exp 20080005 v=0", instr, instr_valid); end
      end
      serve_fetch(32'h0000_0020 + 32'(k), k);
    end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_reach got %h exp 00000010", pc); end
    pulse_update(1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'h14 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++;
      $display("FAIL seq_pc4 got pc=%h req=%b addr=%h exp pc=14 req=1 addr=14", pc, imem_req, imem_addr); end
    $display("txn sequential pc=%h", pc);
    reset_dut();
    first_fetch(32'h1000_FFFE);
    pulse_update(1'b0, 1'b1, 1'b1);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL back_to_top got %h exp fffffffc", pc); end
    serve_fetch(32'h2008_0001, 1);
    pulse_update(1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'd0 || imem_addr !== 32'd0) begin errors++;
      $display("FAIL pc_wrap got pc=%h addr=%h exp 0", pc, imem_addr); end
    $display("txn wrap pc=%h", pc);
  endtask

  task automatic test_branch();
    reset_dut();
    first_fetch(32'h1000_0007);
    pulse_update(1'b0, 1'b1, 1'b1);
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL branch_fwd got %h exp 00000020", pc); end
    serve_fetch(32'h1000_FFFE, 0);
    pulse_update(1'b0, 1'b1, 1'b1);
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL branch_taken got %h exp 0000001c", pc); end
    serve_fetch(32'h1000_0000, 2);
    pulse_update(1'b0, 1'b1, 1'b1);
    serve_fetch(32'h1000_FFFE, 0);
    pulse_update(1'b0, 1'b1, 1'b0);
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL branch_not_taken got %h exp 00000024", pc); end
    serve_fetch(32'h1000_FFFE, 0);
    pulse_update(1'b0, 1'b0, 1'b1);
    checks++; if (pc !== 32'h28) begin errors++; $display("FAIL zero_without_branch got %h exp 00000028", pc); end
    $display("txn branch pc=%h", pc);
  endtask

  task automatic test_jump();
    reset_dut();
    first_fetch(32'h1000_FFFD);
    pulse_update(1'b0, 1'b1, 1'b1);
    checks++; if (pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL branch_back8 got %h exp fffffff8", pc); end
    serve_fetch(32'h0800_0010, 1);
    pulse_update(1'b1, 1'b1, 1'b1);
    checks++; if (pc !== 32'hF000_0040) begin errors++; $display("FAIL jump_priority got %h exp f0000040", pc); end
    $display("txn jump pc=%h", pc);
  endtask

  task automatic test_seq_err();
    tick();
    pulse_update(1'b1, 1'b0, 1'b0);
    checks++; if (pc !== 32'hF000_0040 || seq_err !== 1'b1 || imem_req !== 1'b1) begin errors++;
      $display("FAIL update_in_fetch got pc=%h err=%b req=%b exp pc=f0000040 err=1 req=1", pc, seq_err, imem_req); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'hF000_0040 || imem_req !== 1'b1) begin errors++;
        $display("FAIL addr_stable got addr=%h req=%b exp f0000040 req=1", imem_addr, imem_req); end
    end
    serve_fetch(32'h2008_0005, 0);
    checks++; if (seq_err !== 1'b1 || instr_valid !== 1'b1) begin errors++;
      $display("FAIL seq_err_sticky got err=%b v=%b exp err=1 v=1", seq_err, instr_valid); end
    pulse_update(1'b0, 1'b0, 1'b0);
    checks++; if (pc !== 32'hF000_0044 || seq_err !== 1'b1) begin errors++;
      $display("FAIL hold_update_after_err got pc=%h err=%b exp f0000044 err=1", pc, seq_err); end
    reset = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'd0 || seq_err !== 1'b0 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mid_fetch got req=%b pc=%h err=%b v=%b exp 0", imem_req, pc, seq_err, instr_valid); end
    reset = 1'b0; pcupdate = 1'b1;
    tick();
    pcupdate = 1'b0;
    checks++; if (seq_err !== 1'b1 || pc !== 32'd0 || imem_req !== 1'b1) begin errors++;
      $display("FAIL update_in_idle got err=%b pc=%h req=%b exp err=1 pc=0 req=1", seq_err, pc, imem_req); end
    $display("txn seq_err seq_err=%b", seq_err);
  endtask

  task automatic test_halt();
    reset_dut();
    first_fetch(32'hFC00_0000);
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr !== 32'hFC00_0000 || instr_valid !== 1'b1) begin errors++;
      $display("FAIL halt_fetch got h=%b req=%b instr=%h v=%b exp h=1 req=0 fc000000 v=1", halted, imem_req, instr, instr_valid); end
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
      pulse_update(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++; if (pc !== 32'd0 || seq_err !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b1 || instr !== 32'hFC00_0000) begin errors++;
        $display("FAIL halt_frozen got pc=%h err=%b req=%b h=%b instr=%h", pc, seq_err, imem_req, halted, instr); end
    end
    imem_ready = 1'b0;
    reset_dut();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b exp 0", halted); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++;
      $display("FAIL restart_after_halt got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    $display("txn halt halted=%b", halted);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_instr, word, nxt;
    logic        j, b, z;
    int          w;
    reset_dut();
    exp_instr = 32'h2000_0001;
    first_fetch(exp_instr);
    exp_pc = 32'd0;
    for (int n = 0; n < 40; n++) begin
      j = 1'($urandom); b = 1'($urandom); z = 1'($urandom);
      nxt = ref_next_pc(exp_pc, exp_instr, j, b, z);
      pulse_update(j, b, z);
      exp_pc = nxt;
      checks++; if (pc !== exp_pc || imem_addr !== exp_pc || imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++;
        $display("FAIL rand_update n=%0d got pc=%h req=%b v=%b exp pc=%h req=1 v=0", n, pc, imem_req, instr_valid, exp_pc); end
      word = $urandom;
      if (word[31:26] == 6'h3F) word[31:26] = 6'h04;
      w = $urandom_range(0, 3);
      serve_fetch(word, w);
      exp_instr = word;
      checks++; if (instr !== exp_instr || opcode !== exp_instr[31:26] || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin errors++;
        $display("FAIL rand_fetch n=%0d got instr=%h v=%b req=%b pc=%h exp instr=%h pc=%h", n, instr, instr_valid, imem_req, pc, exp_instr, exp_pc); end
      $display("txn rand %0d j=%b b=%b z=%b wait=%0d pc=%h instr=%h", n, j, b, z, w, pc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_seq_err();
    test_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the program counter and instruction register for the multicycle MIPS core.
- Sits directly upstream of the control unit. It fetches an instruction over a req/ready handshake, holds it stable, and drives opcode to the control unit.
- Consumes the control unit's pcupdate, jump and branch outputs, plus the ALU zero flag, to compute the next PC.
- Enters a halt state when the halt opcode is fetched.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode that halts fetching.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pcupdate  input  1  single-cycle pulse from control unit: commit next PC
- jump  input  1  control unit jump select, sampled with pcupdate
- branch  input  1  control unit branch select, sampled with pcupdate
- zero  input  1  ALU zero flag, sampled with pcupdate
- imem_req  output  1  instruction memory read request
- imem_addr  output  32  instruction memory byte address, equals pc
- imem_rdata  input  32  instruction memory read data
- imem_ready  input  1  read data valid, qualifies imem_rdata
- pc  output  32  current program counter
- instr  output  32  registered instruction
- opcode  output  6  instr[31:26], to control unit
- instr_valid  output  1  instr holds a completed fetch
- halted  output  1  HALT_OPCODE fetched; core stopped
- seq_err  output  1  sticky: pcupdate arrived while not in HOLD

Behaviour:
- Reset (sync, reset high at an edge):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, seq_err=0, state=IDLE.
  - reset overrides all other inputs, in every state, including mid-fetch.
- FSM states: IDLE, FETCH, HOLD, HALT.
  - IDLE: next edge goes to FETCH and sets imem_req=1. The first request is therefore visible one cycle after reset deasserts.
  - FETCH:
    - imem_req=1 and imem_addr=pc, held stable until ready.
    - On an edge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0.
    - If imem_rdata[31:26]==HALT_OPCODE, go to HALT and set halted<=1. Otherwise go to HOLD.
    - Latency: ready sampled at edge N makes instr/instr_valid visible after edge N.
    - Zero-wait memory (ready tied high) gives FETCH lasting 1 cycle.
  - HOLD:
    - instr and opcode stay constant; imem_req=0.
    - On pcupdate=1: pc<=next_pc, instr_valid<=0, imem_req<=1, go to FETCH. instr keeps its old value until overwritten.
  - HALT:
    - imem_req=0 and pc frozen. pcupdate is ignored and does not set seq_err.
    - Only reset exits HALT.
- next_pc, computed from the current pc and instr:
  - pc4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Priority 1, jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - Priority 2, branch=1 and zero=1: pc4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  - Otherwise: pc4. This covers branch=1 with zero=0.
- Boundary conditions:
  - pcupdate in IDLE or FETCH is ignored; pc is unchanged and seq_err<=1 (sticky until reset).
  - imem_ready with imem_req=0 is ignored.
  - jump and branch both high: jump wins.
  - pcupdate is single-cycle by contract. A second pulse that arrives while in FETCH is handled as above (ignored, seq_err set).
- opcode = instr[31:26] combinationally from the register, so it is glitch-free.

Test Plan:
- Reset, RESET_PC=0, ready tied 1, word 0 = 32'h2008_0005 (ADDI) -> imem_req high 1 cycle after reset low; addr 0; instr_valid after next edge; opcode=6'b001000; state HOLD.
- In HOLD with pc=0x10, pcupdate with jump=branch=0 -> pc=0x14, a new request at 0x14. Repeat from pc=0xFFFF_FFFC -> pc=0.
- pc=0x20, instr=32'h1000_FFFE (BEQ, offset -2), pcupdate+branch+zero=1 -> pc=0x1C. Same with zero=0 -> pc=0x24.
- pc=0x3000_0040, instr=32'h0800_0010 (J), pcupdate+jump+branch=1 -> pc=0x3000_0040; jump has priority.
- Ready delayed 3 cycles; pcupdate pulsed during FETCH -> imem_addr stable through the wait; pc unchanged; seq_err=1 and stays 1. Reset asserted mid-fetch -> imem_req=0 and pc=RESET_PC after that edge.
- Fetch 32'hFC00_0000 -> halted=1, imem_req stays 0, and pc is frozen despite pcupdate pulses; seq_err=0. Reset clears halted and fetching restarts at RESET_PC.
